// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding a single registered
// broadcast port, granted round-robin one entry per cycle.
module cdb_arbiter #(
    parameter int NSRC  = 3,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [NSRC-1:0]        ResValid,
    input  logic [4*NSRC-1:0]      ResLabel,
    input  logic [32*NSRC-1:0]     ResData,
    output logic [NSRC-1:0]        ResReady,
    output logic                   BCEN,
    output logic [3:0]             BClabel,
    output logic [31:0]            BCdata,
    output logic                   LabelErr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [CW-1:0] count    [NSRC];
    logic [PW-1:0] wrPtr    [NSRC];
    logic [PW-1:0] rdPtr    [NSRC];
    logic [3:0]    memLabel [NSRC][DEPTH];
    logic [31:0]   memData  [NSRC][DEPTH];

    logic [GW-1:0]   lastGrant;
    logic [NSRC-1:0] pushOk;
    logic [NSRC-1:0] pushBad;
    logic [NSRC-1:0] popSel;
    logic            grantValid;
    logic [GW-1:0]   grantIdx;
    logic [GW-1:0]   cand;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Handshake: a result moves when ResValid[i] and ResReady[i] are both high at a
    // rising edge; ResReady depends only on the registered occupancy, never on
    // ResValid or on a pop in the same cycle. Illegal labels are consumed and dropped.
    always_comb begin
        ResReady = '0;
        pushOk   = '0;
        pushBad  = '0;
        for (int i = 0; i < NSRC; i++) begin
            ResReady[i] = (count[i] < CW'(DEPTH));
            if (ResValid[i] && ResReady[i]) begin
                if ((ResLabel[4*i +: 4] != 4'b0000) && (ResLabel[4*i+2 +: 2] == 2'(i + 1)))
                    pushOk[i] = 1'b1;
                else
                    pushBad[i] = 1'b1;
            end
        end
    end

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        popSel     = '0;
        for (int k = 1; k <= NSRC; k++) begin
            cand = GW'((int'(lastGrant) + k) % NSRC);
            if (!grantValid && (count[cand] != '0)) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
        if (grantValid) popSel[grantIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (pushOk[i]) begin
                memLabel[i][wrPtr[i]] <= ResLabel[4*i +: 4];
                memData[i][wrPtr[i]]  <= ResData[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < NSRC; i++) begin
                count[i] <= '0;
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
            end
            lastGrant <= GW'(NSRC - 1);
            BCEN      <= 1'b0;
            BClabel   <= 4'b0000;
            BCdata    <= 32'h0;
            LabelErr  <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (pushOk[i]) wrPtr[i] <= ptrInc(wrPtr[i]);
                if (popSel[i]) rdPtr[i] <= ptrInc(rdPtr[i]);
                if (pushOk[i] && !popSel[i])
                    count[i] <= count[i] + CW'(1);
                else if (!pushOk[i] && popSel[i])
                    count[i] <= count[i] - CW'(1);
            end
            if (|pushBad) LabelErr <= 1'b1;
            BCEN <= grantValid;
            // Label and data hold their last broadcast value while idle.
            if (grantValid) begin
                lastGrant <= grantIdx;
                BClabel   <= memLabel[grantIdx][rdPtr[grantIdx]];
                BCdata    <= memData[grantIdx][rdPtr[grantIdx]];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, directed multi-cycle sequences and random
// traffic against a queue-based reference model plus a per-source scoreboard.
module tb_cdb_arbiter;

    localparam int NSRC  = 3;
    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  RST;
    logic [NSRC-1:0]       ResValid;
    logic [4*NSRC-1:0]     ResLabel;
    logic [32*NSRC-1:0]    ResData;
    logic [NSRC-1:0]       ResReady;
    logic                  BCEN;
    logic [3:0]            BClabel;
    logic [31:0]           BCdata;
    logic                  LabelErr;

    cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST), .ResValid(ResValid), .ResLabel(ResLabel), .ResData(ResData),
        .ResReady(ResReady), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .LabelErr(LabelErr)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (queues per source) ----------------
    logic [35:0] mq [NSRC][$];
    int          mLast  = NSRC - 1;
    logic        mBcen  = 1'b0;
    logic [3:0]  mLabel = 4'h0;
    logic [31:0] mData  = 32'h0;
    logic        mErr   = 1'b0;
    logic [35:0] accEntry [NSRC];
    logic        accLegal [NSRC];

    function automatic logic isLegal(input int s, input logic [3:0] lab);
        return (lab != 4'b0000) && (int'(lab[3:2]) == s + 1);
    endfunction

    task automatic modelEdge(input logic r, input logic [NSRC-1:0] v,
                             input logic [4*NSRC-1:0] lab, input logic [32*NSRC-1:0] dat);
        int g;
        int s;
        logic [35:0] e;
        bit acc [NSRC];
        for (int i = 0; i < NSRC; i++) accLegal[i] = 1'b0;
        if (r) begin
            for (int i = 0; i < NSRC; i++) mq[i].delete();
            mLast = NSRC - 1; mBcen = 1'b0; mLabel = 4'h0; mData = 32'h0; mErr = 1'b0;
            return;
        end
        for (int i = 0; i < NSRC; i++) acc[i] = v[i] && (mq[i].size() < DEPTH);
        g = -1;
        for (int k = 1; k <= NSRC; k++) begin
            s = (mLast + k) % NSRC;
            if (g < 0 && mq[s].size() > 0) g = s;
        end
        if (g >= 0) begin
            e = mq[g].pop_front();
            mBcen = 1'b1; mLabel = e[35:32]; mData = e[31:0]; mLast = g;
        end else begin
            mBcen = 1'b0;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (acc[i]) begin
                if (isLegal(i, lab[4*i +: 4])) begin
                    mq[i].push_back({lab[4*i +: 4], dat[32*i +: 32]});
                    accLegal[i] = 1'b1;
                    accEntry[i] = {lab[4*i +: 4], dat[32*i +: 32]};
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q [NSRC][$];
    int          waitCnt [NSRC];
    logic [3:0]  bcLog [$];

    task automatic observe();
        int s;
        logic [35:0] e;
        bcLog.push_back(BClabel);
        s = int'(BClabel[3:2]) - 1;
        if (s < 0 || s >= NSRC) begin
            checks++; failures++;
            $display("FAIL sb_station: actual=%0h required=station 1..%0d", BClabel, NSRC);
            return;
        end
        if (exp_q[s].size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected: actual=%0h required=no broadcast", {BClabel, BCdata});
        end else begin
            e = exp_q[s].pop_front();
            chk("sb_order", {BClabel, BCdata}, e);
        end
        for (int t = 0; t < NSRC; t++) begin
            if (t != s && exp_q[t].size() > 0) begin
                waitCnt[t]++;
                chk($sformatf("fair_wait_src%0d", t), waitCnt[t] <= NSRC - 1, 1);
            end
        end
        waitCnt[s] = 0;
    endtask

    // One clock: model and DUT advance together, then everything is compared.
    task automatic step();
        logic r;
        logic [NSRC-1:0] v;
        logic [4*NSRC-1:0] lab;
        logic [32*NSRC-1:0] dat;
        logic [NSRC-1:0] er;
        r = RST; v = ResValid; lab = ResLabel; dat = ResData;
        @(posedge clk);
        modelEdge(r, v, lab, dat);
        #1;
        for (int i = 0; i < NSRC; i++) er[i] = (mq[i].size() < DEPTH);
        chk("m_ready", ResReady, er);
        chk("m_bcen", BCEN, mBcen);
        chk("m_bclabel", BClabel, mLabel);
        chk("m_bcdata", BCdata, mData);
        chk("m_labelerr", LabelErr, mErr);
        if (r) begin
            for (int i = 0; i < NSRC; i++) begin
                exp_q[i].delete();
                waitCnt[i] = 0;
            end
        end else begin
            if (BCEN) observe();
            for (int i = 0; i < NSRC; i++) if (accLegal[i]) exp_q[i].push_back(accEntry[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic setIdle();
        ResValid = '0; ResLabel = '0; ResData = '0;
    endtask

    task automatic drive(input int s, input logic [3:0] lab, input logic [31:0] d);
        ResValid[s] = 1'b1;
        ResLabel[4*s +: 4] = lab;
        ResData[32*s +: 32] = d;
    endtask

    task automatic doReset();
        RST = 1'b1; setIdle(); step(); RST = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              rst;
        logic [NSRC-1:0]   valid;
        logic [4*NSRC-1:0] label;
        logic [32*NSRC-1:0] data;
        logic              bcen;
        logic [3:0]        bclabel;
        logic [31:0]       bcdata;
        logic              err;
        logic [NSRC-1:0]   ready;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [3:0] s1Labs [3];
        logic [3:0] seen [$];
        int s1i;
        int k0;
        logic take1;
        logic take0;

        RST = 1'b1;
        setIdle();

        vecs[0]  = '{1'b1, 3'b000, 12'h000, 96'h0, 1'b0, 4'h0, 32'h0, 1'b0, 3'b111};
        vecs[1]  = '{1'b0, 3'b001, 12'h006, 96'hAA, 1'b0, 4'h0, 32'h0, 1'b0, 3'b111};
        vecs[2]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'h6, 32'hAA, 1'b0, 3'b111};
        vecs[3]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'h6, 32'hAA, 1'b0, 3'b111};
        vecs[4]  = '{1'b1, 3'b000, 12'h000, 96'h0, 1'b0, 4'h0, 32'h0, 1'b0, 3'b111};
        vecs[5]  = '{1'b0, 3'b111, 12'hC84, 96'h00000003_00000002_00000001,
                     1'b0, 4'h0, 32'h0, 1'b0, 3'b111};
        vecs[6]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'h4, 32'h1, 1'b0, 3'b111};
        vecs[7]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'h8, 32'h2, 1'b0, 3'b111};
        vecs[8]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b1, 4'hC, 32'h3, 1'b0, 3'b111};
        vecs[9]  = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'hC, 32'h3, 1'b0, 3'b111};
        vecs[10] = '{1'b0, 3'b001, 12'h000, 96'h5, 1'b0, 4'hC, 32'h3, 1'b1, 3'b111};
        vecs[11] = '{1'b0, 3'b100, 12'h500, 96'h00000006_00000000_00000000,
                     1'b0, 4'hC, 32'h3, 1'b1, 3'b111};
        vecs[12] = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'hC, 32'h3, 1'b1, 3'b111};
        vecs[13] = '{1'b0, 3'b000, 12'h000, 96'h0, 1'b0, 4'hC, 32'h3, 1'b1, 3'b111};

        for (int i = 0; i < 14; i++) begin
            RST = vecs[i].rst; ResValid = vecs[i].valid;
            ResLabel = vecs[i].label; ResData = vecs[i].data;
            step();
            chk($sformatf("vec%0d_bcen", i), BCEN, vecs[i].bcen);
            chk($sformatf("vec%0d_bclabel", i), BClabel, vecs[i].bclabel);
            chk($sformatf("vec%0d_bcdata", i), BCdata, vecs[i].bcdata);
            chk($sformatf("vec%0d_err", i), LabelErr, vecs[i].err);
            chk($sformatf("vec%0d_ready", i), ResReady, vecs[i].ready);
        end
        RST = 1'b0;

        // Backpressure: src0 always offering, src1 pushes three results.
        doReset();
        bcLog.delete();
        s1Labs[0] = 4'b1001; s1Labs[1] = 4'b1010; s1Labs[2] = 4'b1011;
        s1i = 0; k0 = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            setIdle();
            drive(0, {2'b01, 2'(k0)}, 32'h100 + k0);
            if (s1i < 3) drive(1, s1Labs[s1i], 32'h200 + s1i);
            take0 = ResReady[0];
            take1 = (s1i < 3) && ResReady[1];
            step();
            if (take0) k0++;
            if (take1) s1i++;
            if (cyc == 1) chk("bp_ready1_full", ResReady[1], 1'b0);
        end
        setIdle();
        for (int i = 0; i < 6; i++) step();
        chk("bp_all_pushed", s1i, 3);
        seen.delete();
        foreach (bcLog[i]) if (bcLog[i][3:2] == 2'b10) seen.push_back(bcLog[i]);
        chk("bp_src1_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk($sformatf("bp_src1_order%0d", i), seen[i], s1Labs[i]);

        // Streaming: src0 pushes every cycle, one broadcast per cycle.
        doReset();
        for (int k = 0; k < 8; k++) begin
            setIdle();
            drive(0, {2'b01, 2'(k)}, 32'hA000 + k);
            step();
            chk($sformatf("stream_ready0_%0d", k), ResReady[0], 1'b1);
            if (k >= 1) begin
                chk($sformatf("stream_bcen_%0d", k), BCEN, 1'b1);
                chk($sformatf("stream_data_%0d", k), BCdata, 32'hA000 + k - 1);
            end
        end
        setIdle();
        step();
        chk("stream_last_data", BCdata, 32'hA007);
        step();
        chk("stream_idle_bcen", BCEN, 1'b0);

        // Mid-run reset with four entries queued and LabelErr set.
        doReset();
        setIdle();
        drive(0, 4'b0100, 32'h1); drive(1, 4'b1000, 32'h2); drive(2, 4'b1100, 32'h3);
        step();
        setIdle();
        drive(0, 4'b0000, 32'h9); drive(1, 4'b1001, 32'h4); drive(2, 4'b1101, 32'h5);
        step();
        chk("mr_err_set", LabelErr, 1'b1);
        chk("mr_first_bc", BClabel, 4'b0100);
        RST = 1'b1;
        drive(0, 4'b0101, 32'h7); drive(1, 4'b1010, 32'h8); drive(2, 4'b1110, 32'h9);
        step();
        RST = 1'b0;
        setIdle();
        chk("mr_bcen", BCEN, 1'b0);
        chk("mr_err_clr", LabelErr, 1'b0);
        chk("mr_ready", ResReady, 3'b111);
        chk("mr_label", BClabel, 4'h0);
        bcLog.delete();
        for (int i = 0; i < 8; i++) step();
        chk("mr_no_bcast", bcLog.size(), 0);

        // Random traffic against the model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            setIdle();
            RST = ($urandom_range(0, 99) == 0);
            for (int s = 0; s < NSRC; s++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 9) == 0)
                        drive(s, 4'($urandom_range(0, 15)), $urandom);
                    else
                        drive(s, {2'(s + 1), 2'($urandom_range(0, 3))}, $urandom);
                end
            end
            step();
            RST = 1'b0;
        end
        setIdle();
        for (int i = 0; i < 10; i++) step();
        for (int s = 0; s < NSRC; s++)
            chk($sformatf("sb_drained_src%0d", s), exp_q[s].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3, number of result sources (source i drives label station field i+1).
REQ-002 SHALL have parameter DEPTH, default 2, entries per source result queue.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ResValid  input  NSRC  per-source result valid.
REQ-006 SHALL have port ResLabel  input  4*NSRC  per-source producing label {station[1:0],entry[1:0]}, source i in bits [4i+3:4i].
REQ-007 SHALL have port ResData  input  32*NSRC  per-source result value, source i in bits [32i+31:32i].
REQ-008 SHALL have port ResReady  output  NSRC  per-source accept; transfer occurs when ResValid[i] & ResReady[i] at a rising edge.
REQ-009 SHALL have port BCEN  output  1  broadcast enable to all reservation stations and register file.
REQ-010 SHALL have port BClabel  output  4  broadcast label, valid when BCEN=1.
REQ-011 SHALL have port BCdata  output  32  broadcast value, valid when BCEN=1.
REQ-012 SHALL have port LabelErr  output  1  sticky flag, illegal label accepted.

Function
REQ-013 SHALL keep one FIFO of DEPTH {label,data} entries per source, with a 0..DEPTH occupancy counter.
REQ-014 SHALL drive ResReady[i] = (count[i] < DEPTH), combinationally from the registered count only, so ResReady has no dependency on ResValid or on a same-cycle pop.
REQ-015 SHALL, on a transfer, write {ResLabel,ResData} at the source write pointer. The write pointer wraps DEPTH-1 -> 0.
REQ-016 SHALL accept a transfer whose label is 4'b0000 or whose station field is not i+1, discard it without enqueueing, and set LabelErr=1 until reset.
REQ-017 SHALL grant at most one non-empty FIFO per cycle, round-robin: search starts at (last_grant+1) mod NSRC and takes the first non-empty source.
REQ-018 SHALL, on grant, pop the head entry and register it onto BCEN=1/BClabel/BCdata for exactly one cycle (the next cycle). Minimum latency from input transfer edge to BCEN=1 is 1 cycle.
REQ-019 SHALL drive BCEN=0 in any cycle after which no FIFO was non-empty. BClabel and BCdata then hold their previous values.
REQ-020 SHALL update last_grant only when a grant occurs.
REQ-021 SHALL handle a push and a pop on the same FIFO in the same cycle with count unchanged and both pointers advancing.
REQ-022 SHALL let a push to an empty FIFO be granted no earlier than the following cycle (no input-to-BCEN bypass).
REQ-023 SHALL broadcast each accepted legal entry exactly once, preserving per-source order.
REQ-024 SHALL bound the wait of any non-empty source to NSRC-1 grants to other sources.

Reset
REQ-025 SHALL, while RST=1 at a rising edge, clear all counts and pointers, set last_grant=NSRC-1, BCEN=0, BClabel=4'b0000, BCdata=32'h0, LabelErr=0, and discard queued entries.
REQ-026 SHALL make ResReady all-ones in the cycle after reset, since counts are zero.
REQ-027 SHALL, on a reset asserted mid-operation, broadcast nothing queued before reset. Any transfer in the reset cycle is dropped.

Verification
REQ-028 Single result: src0 valid, label 4'b0110, data 32'h0000_00AA at edge N -> BCEN=1, BClabel=4'b0110, BCdata=32'hAA during cycle N+1. BCEN=0 in N+2.
REQ-029 Contention: src0 (4'b0100,32'h1), src1 (4'b1000,32'h2), src2 (4'b1100,32'h3) all at edge N after reset -> broadcasts 4'b0100, 4'b1000, 4'b1100 in cycles N+1, N+2, N+3.
REQ-030 Full/backpressure: src1 pushes 4'b1001, 4'b1010 while src0 is continuously busy -> ResReady[1]=0 once count=2. A third push is held and not lost. All three src1 labels broadcast in order.
REQ-031 Illegal label: src0 sends 4'b0000, then src2 sends 4'b0101 -> neither is broadcast, LabelErr=1 from the next cycle and stays 1.
REQ-032 Simultaneous push/pop: src0 streams a new result every cycle with other sources idle -> one BCEN=1 per cycle, count stays at 1, ResReady[0]=1 throughout.
REQ-033 Mid-run reset: 4 entries queued, RST=1 for one edge -> BCEN=0 and LabelErr=0 next cycle, no queued label ever broadcast afterwards, ResReady=all-ones.
